// File: rtl/ft_alu_pipe.sv
// ft_alu_pipe: two-stage pipelined fault-tolerant adder/subtractor.
// Stage 1 registers the negated or passed operands and the input checks.
// Both the negators and the checks are triplicated and majority-voted.
// Stage 2 runs two independent adders and compares them.
// Any input error or adder disagreement is flagged on the two-rail xe pair.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    operand beat handshake (in_ready is combinational)
//   a, b, par, c         operands, shared odd parity bit, one-hot op select
//   fi                   self-test hook: flips bit 0 of the primary sum in S2
//   out_valid/out_ready  result beat handshake
//   x, xc, xe            sum, carry, two-rail error (10 ok, 11 error)
//   err_cnt, err_clr     saturating count of delivered error beats, clear
module ft_alu_pipe #(
  parameter int unsigned W     = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             par,
  input  logic [2:0]       c,
  input  logic             fi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     x,
  output logic             xc,
  output logic [1:0]       xe,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
);

  localparam int unsigned SW = W + 1;

  function automatic logic [W-1:0] vote_w(input logic [W-1:0] p, input logic [W-1:0] q,
                                          input logic [W-1:0] r);
    return (p & q) | (p & r) | (q & r);
  endfunction

  function automatic logic vote_b(input logic [2:0] t);
    return (t[0] & t[1]) | (t[0] & t[2]) | (t[1] & t[2]);
  endfunction

  // Triplicated negators and input checks
  logic [2:0][W-1:0] nega_t, negb_t;
  logic [2:0]        cw_err_t, ci_err_t;

  for (genvar g = 0; g < 3; g++) begin : g_tmr
    assign nega_t[g]   = ~a + W'(1);
    assign negb_t[g]   = ~b + W'(1);
    assign cw_err_t[g] = ~(^a ^ ^b ^ par);
    assign ci_err_t[g] = (c != 3'b001) && (c != 3'b010) && (c != 3'b100);
  end

  logic [W-1:0] nega_v, negb_v;
  logic         cw_err_v, ci_err_v;

  assign nega_v   = vote_w(nega_t[0], nega_t[1], nega_t[2]);
  assign negb_v   = vote_w(negb_t[0], negb_t[1], negb_t[2]);
  assign cw_err_v = vote_b(cw_err_t);
  assign ci_err_v = vote_b(ci_err_t);

  // Pipeline state
  logic             s1_valid_q, s1_valid_d;
  logic [W-1:0]     opa_q, opa_d, opb_q, opb_d;
  logic             cw_err_q, cw_err_d, ci_err_q, ci_err_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     x_q, x_d;
  logic             xc_q, xc_d;
  logic [1:0]       xe_q, xe_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             s1_adv, s2_adv;
  logic [SW-1:0]    sum_p, sum_s;

  // Duplicated adders; fault injection touches only the primary one
  assign sum_p = (SW'(opa_q) + SW'(opb_q)) ^ SW'(fi);
  assign sum_s = SW'(opa_q) + SW'(opb_q);

  assign s2_adv   = !out_valid_q | out_ready;
  assign s1_adv   = !s1_valid_q | s2_adv;
  assign in_ready = rst_n & s1_adv;

  // Next-state logic for both stages and the error counter
  always_comb begin
    s1_valid_d  = s1_valid_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    cw_err_d    = cw_err_q;
    ci_err_d    = ci_err_q;
    out_valid_d = out_valid_q;
    x_d         = x_q;
    xc_d        = xc_q;
    xe_d        = xe_q;
    err_cnt_d   = err_cnt_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        // Multi-hot selects still compute something; only xe matters then
        opa_d    = c[2] ? nega_v : a;
        opb_d    = c[1] ? negb_v : b;
        cw_err_d = cw_err_v;
        ci_err_d = ci_err_v;
      end
    end

    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        x_d  = sum_p[W-1:0];
        xc_d = sum_p[W];
        xe_d = (cw_err_q | ci_err_q | (sum_p != sum_s)) ? 2'b11 : 2'b10;
      end
    end

    if (err_clr) begin
      err_cnt_d = '0;
    end else if (out_valid_q && out_ready && (xe_q == 2'b11) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      cw_err_q    <= 1'b0;
      ci_err_q    <= 1'b0;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      xc_q        <= 1'b0;
      xe_q        <= 2'b10;
      err_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      cw_err_q    <= cw_err_d;
      ci_err_q    <= ci_err_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      xc_q        <= xc_d;
      xe_q        <= xe_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign x         = x_q;
  assign xc        = xc_q;
  assign xe        = xe_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ft_alu_pipe.sv
// Self-checking bench for ft_alu_pipe (W=3, CNT_W=2).
// A queue-based model predicts every delivered beat from the arithmetic rules.
// Directed tests also check hand-computed literal results.
module tb_ft_alu_pipe;
  localparam int unsigned W     = 3;
  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     a = '0, b = '0;
  logic             par = 1'b0;
  logic [2:0]       c = 3'b001;
  logic             fi = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [W-1:0]     x;
  logic             xc;
  logic [1:0]       xe;
  logic [CNT_W-1:0] err_cnt;
  logic             err_clr = 1'b0;

  ft_alu_pipe #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .par(par), .c(c), .fi(fi),
    .out_valid(out_valid), .out_ready(out_ready),
    .x(x), .xc(xc), .xe(xe), .err_cnt(err_cnt), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0] x;
    logic         xc;
    logic [1:0]   xe;
    bit           chk_x;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   inj_flag = 0;
  int   m_cnt = 0;
  bit   rst_prev = 0;
  bit   stall_prev = 0;
  logic [W-1:0] sx;
  logic sxc;
  logic [1:0] sxe;

  // Expected result from plain modular arithmetic
  function automatic exp_t model(input logic [W-1:0] va_i, input logic [W-1:0] vb_i,
                                 input logic p, input logic [2:0] cc, input bit inj);
    exp_t e;
    int m = 1 << W;
    int va = int'(va_i);
    int vb = int'(vb_i);
    int s;
    bit perr = (((^va_i) ^ (^vb_i) ^ p) == 1'b0);
    bit cerr = ($countones(cc) != 1);
    if (cc == 3'b100) va = (m - va) % m;
    if (cc == 3'b010) vb = (m - vb) % m;
    s = va + vb;
    e.x     = W'(s % m) ^ W'(inj);
    e.xc    = (s >= m);
    e.xe    = (perr || cerr || inj) ? 2'b11 : 2'b10;
    e.chk_x = !cerr;
    return e;
  endfunction

  // Compare process: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    bit xfer;
    if (rst_prev) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_x", 32'(x), 32'd0);
      chk("rst_xc", 32'(xc), 32'd0);
      chk("rst_xe", 32'(xe), 32'd2);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    end
    if (!rst_n) begin
      chk("in_ready_in_reset", 32'(in_ready), 32'd0);
      q.delete();
      m_cnt      = 0;
      stall_prev = 0;
      rst_prev   = 1;
    end else begin
      rst_prev = 0;
      if (stall_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", {27'd0, x, xc, xe}, {27'd0, sx, sxc, sxe});
      end
      chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
      chk("in_ready", 32'(in_ready), 32'(!(q.size() == 2 && !out_ready)));
      if (out_valid) chk("unexpected_beat", 32'(q.size() > 0), 32'd1);
      xfer = out_valid && out_ready;
      if (xfer && q.size() > 0) begin
        cur = q.pop_front();
        if (cur.chk_x) begin
          chk("model_x", 32'(x), 32'(cur.x));
          chk("model_xc", 32'(xc), 32'(cur.xc));
        end
        chk("model_xe", 32'(xe), 32'(cur.xe));
        if (!err_clr && cur.xe == 2'b11 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
      if (err_clr) m_cnt = 0;
      if (in_valid && in_ready) q.push_back(model(a, b, par, c, inj_flag));
      stall_prev = out_valid && !out_ready;
      sx = x; sxc = xc; sxe = xe;
    end
  end

  // Drive one beat and return just after the edge that accepted it
  task automatic push_beat(input logic [W-1:0] va, input logic [W-1:0] vb,
                           input logic p, input logic [2:0] cc);
    bit ok = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; a = va; b = vb; par = p; c = cc;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  // Single beat through an idle pipe with literal expectations
  task automatic send_one(input logic [W-1:0] va, input logic [W-1:0] vb, input logic p,
                          input logic [2:0] cc, input bit inj, input bit cx,
                          input int ex, input int exc, input int exe, input int ecnt);
    bit seen = 0;
    inj_flag = inj;
    push_beat(va, vb, p, cc);
    inj_flag = 0;
    fi = inj;
    @(posedge clk); #1;
    fi = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) chk("out_timeout", 32'd0, 32'd1);
    else begin
      if (cx) begin
        chk("lit_x", 32'(x), 32'(ex));
        chk("lit_xc", 32'(xc), 32'(exc));
      end
      chk("lit_xe", 32'(xe), 32'(exe));
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("lit_err_cnt", 32'(err_cnt), 32'(ecnt));
  endtask

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;

    // Arithmetic and input-error directed beats
    send_one(3'd3, 3'd2, 1'b0, 3'b001, 0, 1, 5, 0, 2, 0);
    send_one(3'd3, 3'd2, 1'b0, 3'b010, 0, 1, 1, 1, 2, 0);
    send_one(3'd2, 3'd0, 1'b0, 3'b100, 0, 1, 6, 0, 2, 0);
    send_one(3'd1, 3'd1, 1'b0, 3'b001, 0, 1, 2, 0, 3, 1);
    send_one(3'd3, 3'd2, 1'b0, 3'b011, 0, 0, 0, 0, 3, 2);
    send_one(3'd3, 3'd2, 1'b0, 3'b000, 0, 0, 0, 0, 3, 3);
    // Fault injection: golden 1+2=3, bit 0 flipped to 2
    send_one(3'd1, 3'd2, 1'b1, 3'b001, 1, 1, 2, 0, 3, 3);
    send_one(3'd1, 3'd2, 1'b1, 3'b001, 0, 1, 3, 0, 2, 3);

    // Backpressure stream with out_ready pattern 1,0,0,1
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          out_ready = (i % 4 == 0) || (i % 4 == 3);
          @(posedge clk); #1;
        end
      end
      begin
        for (int i = 0; i < 6; i++) begin
          logic [W-1:0] ra, rb;
          ra = W'($urandom_range(0, 7));
          rb = W'($urandom_range(0, 7));
          push_beat(ra, rb, ~(^ra ^ ^rb), 3'b001 << $urandom_range(0, 2));
        end
      end
    join
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #1 chk("stream_drained", 32'(q.size()), 32'd0);

    // Counter saturation and clear priority
    err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("cnt_cleared", 32'(err_cnt), 32'd0);
    for (int i = 0; i < 5; i++)
      send_one(3'd1, 3'd1, 1'b0, 3'b001, 0, 1, 2, 0, 3, (i < 3) ? i + 1 : 3);
    chk("cnt_saturated", 32'(err_cnt), 32'd3);
    out_ready = 1'b0;
    push_beat(3'd1, 3'd1, 1'b0, 3'b001);
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    chk("sixth_beat_ready", 32'(seen), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1; err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("clr_over_inc", 32'(err_cnt), 32'd0);

    // Reset with two beats in flight
    out_ready = 1'b0;
    push_beat(3'd3, 3'd2, 1'b0, 3'b001);
    push_beat(3'd2, 3'd0, 1'b0, 3'b100);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_xe", 32'(xe), 32'd2);
    chk("mid_rst_x", 32'(x), 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_stale_beat", 32'(out_valid), 32'd0);
    end
    send_one(3'd3, 3'd2, 1'b0, 3'b001, 0, 1, 5, 0, 2, 0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ft_alu_pipe.md
# ft_alu_pipe

Pipelined, width-parametrised successor of the combinational fault-tolerant 3-bit ALU. It accepts two W-bit operands that share a parity bit, together with a one-hot 3-bit operation select. It computes A+B, A−B or B−A on duplicated adders and returns the sum, the carry and a two-rail error pair. It adds valid/ready handshaking, a two-stage pipeline, a saturating error counter and a fault-injection hook for self-test.

## Interface
Parameters:
- W, 3, operand and result width; must be ≥2.
- CNT_W, 8, error counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- a  in  W  operand A.
- b  in  W  operand B.
- par  in  1  parity bit; a beat is a valid codeword when XOR(a, b, par) = 1, i.e. odd parity.
- c  in  3  operation select, one-hot:
  - 001 = A+B
  - 010 = A+(−B)
  - 100 = (−A)+B
- fi  in  1  fault inject; when high during a beat's stage-2 cycle, it inverts bit 0 of the primary adder sum.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts.
- x  out  W  sum, taken from the primary adder.
- xc  out  1  carry out of the W-bit addition, taken from the primary adder.
- xe  out  2  two-rail error pair: 2'b10 = no error; 2'b11 = error. No other value is emitted.
- err_cnt  out  CNT_W  count of error beats delivered, saturating.
- err_clr  in  1  synchronous clear of err_cnt.

## Operation
- Negation is two's complement modulo 2^W: −V = (~V + 1) mod 2^W. Negating 0 yields 0 with no carry contribution.
- Negated operands come from three identical negators feeding a bitwise 2-of-3 majority voter.
- The sum is (opA + opB), W+1 bits wide: x = sum[W-1:0], xc = sum[W].
- Stage 1 (S1) registers the following on an accepted beat:
  - the negated/passed operands;
  - cw_err = !(^a ^ ^b ^ par);
  - ci_err = (c not exactly one-hot), including 000 and multi-hot.
  - Each check is triplicated and majority-voted.
- Stage 2 (S2) runs two independent W-bit adders on the S1 operands. fi is applied to the primary adder only. S2 registers:
  - x and xc from the primary adder;
  - xe = 2'b11 if cw_err | ci_err | any mismatch in {sum[W:0]} between the two adders, else 2'b10.
- On an input error, x and xc still carry the computed value. Only xe flags the error.
- err_cnt increments by 1 on each output transfer (out_valid & out_ready) with xe=2'b11.
- err_cnt holds at 2^CNT_W−1 once reached (saturation).
- err_clr forces err_cnt to 0 on the next edge and overrides a same-cycle increment.

## Timing
- Handshake rules:
  - Transfer occurs at a rising edge with valid & ready both high.
  - in_valid and operands must be held until accepted.
  - out_valid, x, xc and xe are held stable while out_valid & !out_ready.
- Flow control:
  - s2_adv = !out_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = rst_n & s1_adv (combinational, no bubble).
- Latency: a beat accepted at edge k appears on out_valid/x/xe after edge k+1. With out_ready held high, throughput is 1 beat/cycle.
- Stall: when out_ready is low with both stages full, in_ready drops in the same cycle. No beat is lost or duplicated.
- Reset (rst_n low at an edge):
  - s1_valid = 0, out_valid = 0;
  - x = 0, xc = 0, xe = 2'b10, err_cnt = 0;
  - in_ready reads 0 while rst_n is low.
- Reset mid-operation discards all in-flight beats. The first beat after reset behaves as from idle.
- Simultaneous accept and emit in one cycle is legal. The pipeline shifts both stages.

## Test plan
- W=3, c=001, a=3, b=2, par=0 (valid codeword), out_ready=1 -> after 2 edges: x=5, xc=0, xe=10; err_cnt=0.
- W=3, c=010, a=3, b=2, par=0 -> x=1, xc=1, xe=10. Repeat with c=100, a=2, b=0, par=0 -> x=6, xc=0, xe=10.
- Input error checks, each with out_ready=1:
  - Parity error: a=1, b=1, par=0 -> xe=11, err_cnt=1.
  - Control error: c=011 with valid parity -> xe=11, err_cnt=2.
  - Control error: c=000 -> xe=11, err_cnt=3.
- Fault injection: fi=1 during a clean beat's S2 cycle -> xe=11, x bit 0 inverted versus the golden sum. The following beat with fi=0 -> xe=10.
- Backpressure:
  - Stream 6 random valid beats with out_ready toggling 1,0,0,1,…
  - Required: results in order, each exactly once, with outputs stable while stalled.
  - Required: in_ready=0 whenever both stages are full and out_ready=0.
- Counter and reset:
  - With CNT_W=2, deliver 5 error beats -> err_cnt=3 (saturated).
  - Assert err_clr together with a 6th error beat -> err_cnt=0.
  - Drop rst_n with 2 beats in flight -> next edge: out_valid=0, xe=10, x=0; no stale beat emerges afterwards.
